// File: rtl/lt_spi_pkg.sv
// lt_spi_pkg: shared constants, FSM state type and frame builder for the SPI register master.
package lt_spi_pkg;
    localparam int FRAME_BITS = 16;
    localparam logic [6:0] REG_CONFIG  = 7'h00;
    localparam logic [6:0] REG_DATA_GS = 7'h0C;
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW, ST_GAP, ST_HOLD, ST_RECOVER
    } spi_state_t;
    // Address byte {wr, addr} then data byte; reads shift out zeros.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic w, input logic [6:0] a, input logic [7:0] d);
        return {w, a, w ? d : 8'h00};
    endfunction
endpackage

// File: rtl/lt_spi_master_tick.sv
// lt_spi_master_tick: half-period counter; tick marks the last cycle of each DIV-cycle state.
// Ports: theClock, theReset (async, active high), en (count while busy), tick (out).
module lt_spi_master_tick #(
    parameter int DIV = 8
) (
    input  logic theClock,
    input  logic theReset,
    input  logic en,
    output logic tick
);
    logic [7:0] cnt;

    assign tick = en && cnt == 8'(DIV - 1);

    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset)
            cnt <= 8'd0;
        else
            cnt <= (tick || !en) ? 8'd0 : cnt + 8'd1;
    end
endmodule

// File: rtl/lt_spi_master.sv
// lt_spi_master: 16-bit register-access SPI master (mode 0, MSB first, GAP between address and data byte).
// Ports: theClock/theReset (async, active high); req/wr/addr/wdata request, ready/done/rdata/verify_err status;
//        MySPI_clk/MySPI_cs/MySPI_sdo/MySPI_sdi serial bus.
// Macro LT_SPI_MASTER_READBACK_EN: every write is followed by a readback frame and compared.
module lt_spi_master
    import lt_spi_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic       theClock,
    input  logic       theReset,
    input  logic       req,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       verify_err,
    output logic       MySPI_clk,
    output logic       MySPI_cs,
    output logic       MySPI_sdo,
    input  logic       MySPI_sdi
);
    spi_state_t  state;
    logic        tick, last, start, rb_next, rb_go;
    logic [3:0]  bit_cnt;
    logic [14:0] sh;
    logic [7:0]  rx;
    logic [15:0] rb_frame;

    lt_spi_master_tick #(.DIV(DIV)) u_tick (
        .theClock(theClock),
        .theReset(theReset),
        .en      (state != ST_IDLE),
        .tick    (tick)
    );

    // The final RECOVER cycle can already accept, so a held req restarts with
    // exactly DIV cycles of cs high and a 36*DIV request-to-request period.
    assign ready = state == ST_IDLE || (state == ST_RECOVER && tick && !rb_next);
    assign start = req && ready;
    assign rb_go = state == ST_RECOVER && tick && rb_next;

    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) begin
            state     <= ST_IDLE;
            MySPI_cs  <= 1'b1;
            MySPI_clk <= 1'b0;
            MySPI_sdo <= 1'b0;
            sh        <= '0;
            bit_cnt   <= '0;
            last      <= 1'b0;
            rx        <= '0;
            rdata     <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || rb_go) begin
                state            <= ST_SETUP;
                MySPI_cs         <= 1'b0;
                MySPI_clk        <= 1'b0;
                {MySPI_sdo, sh}  <= start ? frame_word(wr, addr, wdata) : rb_frame;
                bit_cnt          <= '0;
                last             <= 1'b0;
            end else if (tick) begin
                case (state)
                    ST_SETUP, ST_GAP, ST_LOW: begin
                        if (state == ST_LOW && last)
                            state <= ST_HOLD;
                        else if (state == ST_LOW && bit_cnt == 4'd8)
                            state <= ST_GAP;
                        else begin
                            state     <= ST_HIGH;
                            MySPI_clk <= 1'b1;
                            // bit_cnt 8..15 on a rising edge means a data-byte bit
                            if (bit_cnt[3])
                                rx <= {rx[6:0], MySPI_sdi};
                        end
                    end
                    ST_HIGH: begin
                        state     <= ST_LOW;
                        MySPI_clk <= 1'b0;
                        // the 4-bit counter cannot hold 16, so the 16th fall is flagged instead
                        if (bit_cnt == 4'd15)
                            last <= 1'b1;
                        else begin
                            bit_cnt         <= bit_cnt + 4'd1;
                            {MySPI_sdo, sh} <= {sh, 1'b0};
                        end
                    end
                    ST_HOLD: begin
                        state    <= ST_RECOVER;
                        MySPI_cs <= 1'b1;
                        done     <= !rb_next;
                        if (!rb_next)
                            rdata <= rx;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef LT_SPI_MASTER_READBACK_EN
    logic       wr_q, chk, verr;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;

    assign rb_next    = wr_q;
    assign rb_frame   = frame_word(1'b0, addr_q, 8'h00);
    assign verify_err = verr;

    // wr_q marks a write frame still owing its readback; chk survives into the readback frame.
    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) begin
            wr_q    <= 1'b0;
            chk     <= 1'b0;
            verr    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (start) begin
                wr_q    <= wr;
                chk     <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
            end else if (rb_go)
                wr_q <= 1'b0;
            if (state == ST_HOLD && tick && !wr_q)
                verr <= chk && rx != wdata_q;
        end
    end
`else
    assign rb_next    = 1'b0;
    assign rb_frame   = '0;
    assign verify_err = 1'b0;
`endif
endmodule

// File: tb/tb_lt_spi_master.sv
// tb_lt_spi_master: directed self-checking bench for lt_spi_master with a behavioural SPI slave.
module tb_lt_spi_master;
    localparam int DIV = 8;
`ifdef LT_SPI_MASTER_READBACK_EN
    localparam int NF = 2;
`else
    localparam int NF = 1;
`endif

    logic       theClock = 1'b0, theReset = 1'b1, req = 1'b0, wr = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0, resp = '0;
    logic       ready, done, verify_err, MySPI_clk, MySPI_cs, MySPI_sdo;
    logic       MySPI_sdi = 1'b0;
    logic [7:0] rdata;
    logic [15:0] mosi = '0;
    int passed = 0, total = 0;
    int rises = 0, dones = 0, cs_low = 0, frames = 0, fall_cnt = 0;

    lt_spi_master #(.DIV(DIV)) dut (
        .theClock  (theClock),
        .theReset  (theReset),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .rdata     (rdata),
        .verify_err(verify_err),
        .MySPI_clk (MySPI_clk),
        .MySPI_cs  (MySPI_cs),
        .MySPI_sdo (MySPI_sdo),
        .MySPI_sdi (MySPI_sdi)
    );

    always #5 theClock = ~theClock;

    always @(posedge MySPI_clk) begin
        mosi = {mosi[14:0], MySPI_sdo};
        rises++;
    end

    // slave: after the 8th falling edge it presents resp MSB first, one bit per fall
    always @(negedge MySPI_clk or posedge MySPI_cs)
        if (MySPI_cs)
            fall_cnt = 0;
        else begin
            fall_cnt++;
            if (fall_cnt >= 8 && fall_cnt < 16)
                MySPI_sdi = resp[3'(15 - fall_cnt)];
        end

    always @(negedge theClock) begin
        if (done) dones++;
        if (!MySPI_cs) cs_low++;
    end

    always @(negedge MySPI_cs) frames++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic xfer(input logic w, input logic [6:0] a, input logic [7:0] d, input logic [7:0] r, input int poke);
        int n, r0, d0, c0, f0, nf;
        nf = w ? NF : 1;
        resp = r;
        r0 = rises; d0 = dones; c0 = cs_low; f0 = frames;
        @(negedge theClock);
        check("ready_idle", ready, 1);
        req = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge theClock);
        #1;
        req = 1'b0; wr = ~w; addr = ~a; wdata = ~d;
        n = 0;
        while (n < 2000) begin
            @(negedge theClock);
            n++;
            if (ready) break;
            req = (n == poke);
        end
        req = 1'b0;
        check("latency", n, 36 * DIV * nf);
        check("clk_rises", rises - r0, 16 * nf);
        check("cs_low_cycles", cs_low - c0, 35 * DIV * nf);
        check("frames", frames - f0, nf);
        check("done_pulses", dones - d0, 1);
        check("mosi", mosi, nf == 2 ? {1'b0, a, 8'h00} : {w, a, w ? d : 8'h00});
        check("rdata", rdata, r);
        check("verify_err", verify_err, NF == 2 && w && r != d);
    endtask

    initial begin
        int n, f0, d0, r0, a1, a2, hi;
        repeat (3) @(negedge theClock);
        check("rst_cs", MySPI_cs, 1);
        check("rst_clk", MySPI_clk, 0);
        check("rst_sdo", MySPI_sdo, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_verify", verify_err, 0);
        theReset = 1'b0;
        @(negedge theClock);
        check("rst_ready", ready, 1);

        xfer(1'b1, 7'h06, 8'hA5, 8'h00, 0);
        xfer(1'b0, 7'h02, 8'h77, 8'h3C, 0);

        // back-to-back reads with req held high
        f0 = frames; d0 = dones; resp = 8'h81;
        @(negedge theClock);
        req = 1'b1; wr = 1'b0; addr = 7'h0B; wdata = 8'h00;
        n = 0; a1 = -1; a2 = -1; hi = 0;
        while (a2 < 0 && n < 2000) begin
            if (a1 >= 0 && MySPI_cs) hi++;
            if (ready) begin
                if (a1 < 0) a1 = n;
                else a2 = n;
            end
            if (a2 < 0) begin
                @(negedge theClock);
                n++;
            end
        end
        check("b2b_period", a2 - a1, 36 * DIV);
        check("b2b_cs_high", hi, DIV);
        @(posedge theClock);
        #1;
        req = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(negedge theClock);
            n++;
            if (ready) break;
        end
        check("b2b_second_latency", n, 36 * DIV);
        check("b2b_frames", frames - f0, 2);
        check("b2b_dones", dones - d0, 2);
        check("b2b_mosi", mosi, 16'h0B00);
        check("b2b_rdata", rdata, 8'h81);

        // reset after the 5th SPI clock rise
        d0 = dones; r0 = rises; resp = 8'hFF;
        @(negedge theClock);
        req = 1'b1; wr = 1'b1; addr = 7'h05; wdata = 8'h11;
        @(posedge theClock);
        #1;
        req = 1'b0;
        n = 0;
        while (rises - r0 < 5 && n < 2000) begin
            @(negedge theClock);
            n++;
        end
        check("abort_clk_high", MySPI_clk, 1);
        #2 theReset = 1'b1;
        #1;
        check("abort_cs", MySPI_cs, 1);
        check("abort_clk", MySPI_clk, 0);
        check("abort_sdo", MySPI_sdo, 0);
        check("abort_done", done, 0);
        check("abort_rdata", rdata, 0);
        @(negedge theClock);
        theReset = 1'b0;
        repeat (400) @(negedge theClock);
        check("abort_no_done", dones - d0, 0);
        check("abort_ready", ready, 1);
        xfer(1'b1, 7'h0C, 8'h5A, 8'h5A, 0);

        // req pulse while busy must be ignored
        xfer(1'b0, 7'h00, 8'h00, 8'hC3, 100);
        f0 = frames; d0 = dones;
        repeat (100) @(negedge theClock);
        check("busy_no_frame", frames - f0, 0);
        check("busy_no_done", dones - d0, 0);

        // readback compare (expectations follow the build configuration)
        xfer(1'b1, 7'h07, 8'h55, 8'h54, 0);
        xfer(1'b1, 7'h07, 8'h55, 8'h55, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
